// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the dispense sequencer.
//   state_t      - sequencer states
//   fault_code_t - latched fault cause reported on fault_code
//   G1/G2/G3     - one-hot slot encodings for req_sell / motor_en
//   CHANGE_W     - width of change / coin counters
package vend_pkg;

  localparam int CHANGE_W = 4;

  localparam logic [2:0] G1 = 3'b001;
  localparam logic [2:0] G2 = 3'b010;
  localparam logic [2:0] G3 = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VEND,
    S_PULSE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE   = 2'd0,
    FC_MOTOR  = 2'd1,
    FC_HOPPER = 2'd2,
    FC_SELL   = 2'd3
  } fault_code_t;

  // True only for a single valid product slot; zero (refund) is not a slot.
  function automatic logic is_slot(input logic [2:0] sell);
    return (sell == G1) || (sell == G2) || (sell == G3);
  endfunction

endpackage

// File: rtl/vend_timer.sv
// vend_timer: loadable saturating down-counter shared by all timed states.
//   clk, rst - clock and asynchronous active-high reset
//   load     - capture value this cycle
//   value    - count to load; a window of N cycles is loaded as N-1
//   expired  - high while the count sits at zero (last cycle of the window)
module vend_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  // Count down once per cycle after a load, holding at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: dispense sequencer for the vending FSM.
// Takes one transaction (sell slot + change count) per handshake, runs the
// product motor until drop_det, then pulses the coin hopper once per coin,
// waiting for coin_det after each pulse. Timeouts latch a fault code and
// stop all actuators until fault_clr.
//   clk, rst             - clock, asynchronous active-high reset
//   req_valid/req_ready  - transaction handshake (ready only in IDLE)
//   req_sell, req_change - one-hot slot (0 = refund only), coins to pay out
//   drop_det, coin_det   - synchronised product-drop / coin-exit sensors
//   fault_clr            - leave FAULT
//   motor_en             - one-hot motor drive
//   hopper_pulse         - one-cycle coin eject
//   coins_paid           - coins confirmed for current/last transaction
//   busy, done, fault    - status; done is a one-cycle completion pulse
//   fault_code           - 0 none, 1 motor, 2 hopper, 3 bad sell
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int MOTOR_CYC = 8,
  parameter int ACK_CYC   = 16,
  parameter int GAP_CYC   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_sell,
  input  logic [CHANGE_W-1:0] req_change,
  input  logic                drop_det,
  input  logic                coin_det,
  input  logic                fault_clr,
  output logic [2:0]          motor_en,
  output logic                hopper_pulse,
  output logic [CHANGE_W-1:0] coins_paid,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [1:0]          fault_code
);

  localparam int TMR_MAX =
    (MOTOR_CYC > ACK_CYC) ? ((MOTOR_CYC > GAP_CYC) ? MOTOR_CYC : GAP_CYC)
                          : ((ACK_CYC   > GAP_CYC) ? ACK_CYC   : GAP_CYC);
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  // Windows of N cycles load N-1 so expired marks the final window cycle.
  localparam logic [TMR_W-1:0] MOTOR_LD = TMR_W'(MOTOR_CYC - 1);
  localparam logic [TMR_W-1:0] ACK_LD   = TMR_W'(ACK_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);

  localparam logic [CHANGE_W-1:0] COIN_ONE = CHANGE_W'(1);

  state_t state, next_state;

  logic [2:0]          sell_q;
  logic [CHANGE_W-1:0] remaining;

  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_value;
  logic                tmr_expired;

  logic                accept;
  logic                coin_ok;

  logic                req_ready_nxt;
  logic [2:0]          motor_en_nxt;
  logic                hopper_pulse_nxt;
  logic [CHANGE_W-1:0] coins_paid_nxt;
  logic                busy_nxt;
  logic                done_nxt;
  logic                fault_nxt;
  fault_code_t         fault_code_nxt;

  assign accept  = (state == S_IDLE) && req_valid && req_ready;
  // A coin only counts while one is still owed, so coins_paid cannot pass change.
  assign coin_ok = (state == S_WAIT) && coin_det && (remaining != '0);

  vend_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  // State and registered outputs; outputs are precomputed from next_state
  // so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      req_ready    <= 1'b1;
      motor_en     <= '0;
      hopper_pulse <= 1'b0;
      coins_paid   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      fault_code   <= FC_NONE;
    end else begin
      state        <= next_state;
      req_ready    <= req_ready_nxt;
      motor_en     <= motor_en_nxt;
      hopper_pulse <= hopper_pulse_nxt;
      coins_paid   <= coins_paid_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      fault        <= fault_nxt;
      fault_code   <= fault_code_nxt;
    end
  end

  // Latched transaction: slot for the motor and coins still owed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sell_q    <= '0;
      remaining <= '0;
    end else if (accept) begin
      sell_q    <= req_sell;
      remaining <= req_change;
    end else if (coin_ok) begin
      remaining <= remaining - COIN_ONE;
    end
  end

  // Next-state logic plus timer reload on entry to each timed state.
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_value  = '0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_sell == '0) begin
            next_state = (req_change != '0) ? S_PULSE : S_DONE;
          end else if (is_slot(req_sell)) begin
            next_state = S_VEND;
          end else begin
            next_state = S_FAULT;
          end
        end
      end
      S_VEND: begin
        // A drop on the last window cycle still wins over the timeout.
        if (drop_det) begin
          next_state = (remaining != '0) ? S_PULSE : S_DONE;
        end else if (tmr_expired) begin
          next_state = S_FAULT;
        end
      end
      S_PULSE: next_state = S_WAIT;
      S_WAIT: begin
        if (coin_det) begin
          next_state = (remaining == COIN_ONE) ? S_DONE : S_GAP;
        end else if (tmr_expired) begin
          next_state = S_FAULT;
        end
      end
      S_GAP: begin
        if (tmr_expired) begin
          next_state = S_PULSE;
        end
      end
      S_DONE: next_state = S_IDLE;
      S_FAULT: begin
        if (fault_clr) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase

    if (next_state != state) begin
      case (next_state)
        S_VEND: begin tmr_load = 1'b1; tmr_value = MOTOR_LD; end
        S_WAIT: begin tmr_load = 1'b1; tmr_value = ACK_LD;   end
        S_GAP:  begin tmr_load = 1'b1; tmr_value = GAP_LD;   end
        default: begin tmr_load = 1'b0; tmr_value = '0; end
      endcase
    end
  end

  // Output values for the coming cycle, decoded from next_state.
  always_comb begin
    req_ready_nxt    = (next_state == S_IDLE);
    busy_nxt         = (next_state != S_IDLE);
    hopper_pulse_nxt = (next_state == S_PULSE);
    done_nxt         = (next_state == S_DONE);
    fault_nxt        = (next_state == S_FAULT);

    motor_en_nxt = '0;
    if (next_state == S_VEND) begin
      // On the accept edge the slot is not latched yet, so use the request.
      motor_en_nxt = (state == S_IDLE) ? req_sell : sell_q;
    end

    coins_paid_nxt = coins_paid;
    if (accept) begin
      coins_paid_nxt = '0;
    end else if (coin_ok) begin
      coins_paid_nxt = coins_paid + COIN_ONE;
    end

    fault_code_nxt = fault_code_t'(fault_code);
    if (state != S_FAULT && next_state == S_FAULT) begin
      case (state)
        S_IDLE:  fault_code_nxt = FC_SELL;
        S_VEND:  fault_code_nxt = FC_MOTOR;
        S_WAIT:  fault_code_nxt = FC_HOPPER;
        default: fault_code_nxt = fault_code_t'(fault_code);
      endcase
    end else if (state == S_FAULT && next_state == S_IDLE) begin
      fault_code_nxt = FC_NONE;
    end
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb_vend_dispense_ctrl: table-driven single-cycle vectors followed by
// reactive multi-cycle sequences for the dispense sequencer.
module tb_vend_dispense_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_sell;
  logic [3:0] req_change;
  logic       drop_det;
  logic       coin_det;
  logic       fault_clr;
  logic [2:0] motor_en;
  logic       hopper_pulse;
  logic [3:0] coins_paid;
  logic       busy;
  logic       done;
  logic       fault;
  logic [1:0] fault_code;

  always #5 clk = ~clk;

  vend_dispense_ctrl #(
    .MOTOR_CYC (8),
    .ACK_CYC   (16),
    .GAP_CYC   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sell     (req_sell),
    .req_change   (req_change),
    .drop_det     (drop_det),
    .coin_det     (coin_det),
    .fault_clr    (fault_clr),
    .motor_en     (motor_en),
    .hopper_pulse (hopper_pulse),
    .coins_paid   (coins_paid),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  typedef struct packed {
    logic       valid;
    logic [2:0] sell;
    logic [3:0] change;
    logic       drop;
    logic       coin;
    logic       clr;
  } ins_t;

  typedef struct packed {
    logic       rdy;
    logic [2:0] mot;
    logic       pul;
    logic [3:0] cns;
    logic       bsy;
    logic       dn;
    logic       flt;
    logic [1:0] code;
  } outs_t;

  typedef struct {
    ins_t  stim;
    outs_t want;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  int tests_run    = 0;
  int tests_failed = 0;

  int         motor_cycles;
  int         first_motor;
  logic [2:0] motor_val;
  int         done_cycle;
  int         fault_cycle;
  int         pulse_q [$];

  function automatic ins_t mkIn(input logic v, input logic [2:0] s, input logic [3:0] c,
                                input logic d, input logic k, input logic x);
    ins_t r;
    r.valid = v; r.sell = s; r.change = c; r.drop = d; r.coin = k; r.clr = x;
    return r;
  endfunction

  function automatic outs_t mkOut(input logic rd, input logic [2:0] m, input logic p,
                                  input logic [3:0] c, input logic b, input logic dn,
                                  input logic f, input logic [1:0] fc);
    outs_t r;
    r.rdy = rd; r.mot = m; r.pul = p; r.cns = c; r.bsy = b; r.dn = dn; r.flt = f; r.code = fc;
    return r;
  endfunction

  function automatic outs_t sampleOuts();
    return mkOut(req_ready, motor_en, hopper_pulse, coins_paid, busy, done, fault, fault_code);
  endfunction

  function automatic int pulseAt(input int i);
    if (i < pulse_q.size()) return pulse_q[i];
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input ins_t v);
    req_valid  = v.valid;
    req_sell   = v.sell;
    req_change = v.change;
    drop_det   = v.drop;
    coin_det   = v.coin;
    fault_clr  = v.clr;
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    req_valid = 1'b0; req_sell = '0; req_change = '0;
    drop_det = 1'b0; coin_det = 1'b0; fault_clr = 1'b0;
  endtask

  // Offers one transaction, then answers motor/hopper activity like the
  // mechanics would: drop_det on motor cycle drop_after+1, coin_det
  // coin_after cycles after each of the first ack_pulses pulses.
  task automatic runTxn(input string name, input logic [2:0] sell, input logic [3:0] change,
                        input int drop_after, input int coin_after, input int ack_pulses);
    int c;
    int last_pulse;
    bit finished;
    motor_cycles = 0; first_motor = -1; motor_val = '0;
    done_cycle = -1; fault_cycle = -1; pulse_q.delete();
    applyStimulus(mkIn(1'b1, sell, change, 1'b0, 1'b0, 1'b0));
    req_valid = 1'b0;
    c = 1; last_pulse = -100; finished = 1'b0;
    while (!finished && c <= 200) begin
      drop_det = 1'b0;
      coin_det = 1'b0;
      if (motor_en != '0) begin
        motor_cycles++;
        if (first_motor < 0) begin
          first_motor = c;
          motor_val = motor_en;
        end
        if (drop_after >= 0 && motor_cycles == drop_after + 1) drop_det = 1'b1;
      end
      if (hopper_pulse) begin
        pulse_q.push_back(c);
        last_pulse = c;
      end
      if (pulse_q.size() > 0 && pulse_q.size() <= ack_pulses && c == last_pulse + coin_after)
        coin_det = 1'b1;
      if (done) begin done_cycle = c; finished = 1'b1; end
      if (fault) begin fault_cycle = c; finished = 1'b1; end
      if (!finished) begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    drop_det = 1'b0;
    coin_det = 1'b0;
    checkOutput({name, "_completed_in_budget"}, 32'(finished), 32'd1);
  endtask

  initial begin
    int busy_seen;
    int pulses_seen;

    // Expected values below assume MOTOR_CYC=8, ACK_CYC=16, GAP_CYC=4.
    // Empty request: done right after accept, ready back the cycle after.
    vecs[0]  = '{mkIn(0, 3'b000, 4'd0, 0, 0, 0), mkOut(1, 3'b000, 0, 4'd0, 0, 0, 0, 2'd0)};
    vecs[1]  = '{mkIn(1, 3'b000, 4'd0, 0, 0, 0), mkOut(0, 3'b000, 0, 4'd0, 1, 1, 0, 2'd0)};
    vecs[2]  = '{mkIn(0, 3'b000, 4'd0, 0, 0, 0), mkOut(1, 3'b000, 0, 4'd0, 0, 0, 0, 2'd0)};
    // Bad sell: fault code 3 next cycle; held request and sensors ignored.
    vecs[3]  = '{mkIn(1, 3'b110, 4'd2, 0, 0, 0), mkOut(0, 3'b000, 0, 4'd0, 1, 0, 1, 2'd3)};
    vecs[4]  = '{mkIn(1, 3'b001, 4'd1, 0, 0, 0), mkOut(0, 3'b000, 0, 4'd0, 1, 0, 1, 2'd3)};
    vecs[5]  = '{mkIn(0, 3'b000, 4'd0, 1, 1, 0), mkOut(0, 3'b000, 0, 4'd0, 1, 0, 1, 2'd3)};
    vecs[6]  = '{mkIn(0, 3'b000, 4'd0, 0, 0, 1), mkOut(1, 3'b000, 0, 4'd0, 0, 0, 0, 2'd0)};
    // Sensors in IDLE ignored; single-coin refund, coin_det during PULSE ignored.
    vecs[7]  = '{mkIn(0, 3'b000, 4'd0, 1, 1, 0), mkOut(1, 3'b000, 0, 4'd0, 0, 0, 0, 2'd0)};
    vecs[8]  = '{mkIn(1, 3'b000, 4'd1, 0, 0, 0), mkOut(0, 3'b000, 1, 4'd0, 1, 0, 0, 2'd0)};
    vecs[9]  = '{mkIn(0, 3'b000, 4'd0, 0, 1, 0), mkOut(0, 3'b000, 0, 4'd0, 1, 0, 0, 2'd0)};
    vecs[10] = '{mkIn(0, 3'b000, 4'd0, 0, 1, 0), mkOut(0, 3'b000, 0, 4'd1, 1, 1, 0, 2'd0)};
    vecs[11] = '{mkIn(0, 3'b000, 4'd0, 0, 0, 0), mkOut(1, 3'b000, 0, 4'd1, 0, 0, 0, 2'd0)};

    clearInputs();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset_state", 32'(sampleOuts()), 32'(mkOut(1, 3'b000, 0, 4'd0, 0, 0, 0, 2'd0)));
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].stim);
      checkOutput($sformatf("vec%0d", i), 32'(sampleOuts()), 32'(vecs[i].want));
    end
    clearInputs();

    // Product with change: drop 3 cycles after motor rises, coin 2 cycles after each pulse.
    runTxn("prod", 3'b010, 4'd3, 3, 2, 99);
    checkOutput("prod_motor_first", 32'(first_motor), 32'd1);
    checkOutput("prod_motor_val", 32'(motor_val), 32'(3'b010));
    checkOutput("prod_motor_cycles", 32'(motor_cycles), 32'd4);
    checkOutput("prod_pulse_count", 32'(pulse_q.size()), 32'd3);
    checkOutput("prod_pulse0", 32'(pulseAt(0)), 32'd5);
    checkOutput("prod_pulse1", 32'(pulseAt(1)), 32'd12);
    checkOutput("prod_pulse2", 32'(pulseAt(2)), 32'd19);
    checkOutput("prod_done_cycle", 32'(done_cycle), 32'd22);
    checkOutput("prod_no_fault", 32'(fault_cycle), 32'hFFFF_FFFF);
    checkOutput("prod_coins", 32'(coins_paid), 32'd3);
    @(posedge clk); #1;
    checkOutput("prod_idle_after", 32'(sampleOuts()), 32'(mkOut(1, 3'b000, 0, 4'd3, 0, 0, 0, 2'd0)));

    // Refund only.
    runTxn("refund", 3'b000, 4'd2, -1, 2, 99);
    checkOutput("refund_no_motor", 32'(motor_cycles), 32'd0);
    checkOutput("refund_pulse_count", 32'(pulse_q.size()), 32'd2);
    checkOutput("refund_pulse0", 32'(pulseAt(0)), 32'd1);
    checkOutput("refund_pulse1", 32'(pulseAt(1)), 32'd8);
    checkOutput("refund_done_cycle", 32'(done_cycle), 32'd11);
    checkOutput("refund_coins", 32'(coins_paid), 32'd2);

    // Motor jam: no drop_det at all.
    @(posedge clk); #1;
    runTxn("jam", 3'b001, 4'd2, -1, 2, 99);
    checkOutput("jam_motor_cycles", 32'(motor_cycles), 32'd8);
    checkOutput("jam_fault_cycle", 32'(fault_cycle), 32'd9);
    checkOutput("jam_outs", 32'(sampleOuts()), 32'(mkOut(0, 3'b000, 0, 4'd0, 1, 0, 1, 2'd1)));
    checkOutput("jam_no_pulse", 32'(pulse_q.size()), 32'd0);
    applyStimulus(mkIn(0, 3'b000, 4'd0, 0, 0, 1));
    checkOutput("jam_cleared", 32'(sampleOuts()), 32'(mkOut(1, 3'b000, 0, 4'd0, 0, 0, 0, 2'd0)));
    clearInputs();

    // Hopper empty: only the first pulse is acknowledged.
    runTxn("empty", 3'b000, 4'd3, -1, 2, 1);
    checkOutput("empty_pulse_count", 32'(pulse_q.size()), 32'd2);
    checkOutput("empty_fault_cycle", 32'(fault_cycle), 32'd25);
    checkOutput("empty_outs", 32'(sampleOuts()), 32'(mkOut(0, 3'b000, 0, 4'd1, 1, 0, 1, 2'd2)));
    applyStimulus(mkIn(0, 3'b000, 4'd0, 0, 1, 0));
    checkOutput("empty_coins_frozen", 32'(coins_paid), 32'd1);
    applyStimulus(mkIn(0, 3'b000, 4'd0, 0, 0, 1));
    checkOutput("empty_cleared", 32'(sampleOuts()), 32'(mkOut(1, 3'b000, 0, 4'd1, 0, 0, 0, 2'd0)));
    clearInputs();

    // Repeat run, reset asynchronously mid-transaction during GAP.
    applyStimulus(mkIn(1, 3'b000, 4'd3, 0, 0, 0));
    checkOutput("rerun_pulse", 32'(hopper_pulse), 32'd1);
    applyStimulus(mkIn(0, 3'b000, 4'd0, 0, 0, 0));
    applyStimulus(mkIn(0, 3'b000, 4'd0, 0, 1, 0));
    checkOutput("rerun_coins", 32'(coins_paid), 32'd1);
    clearInputs();
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_outs", 32'(sampleOuts()), 32'(mkOut(1, 3'b000, 0, 4'd0, 0, 0, 0, 2'd0)));
    @(posedge clk); #1;
    rst = 1'b0;
    busy_seen = 0;
    pulses_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (busy) busy_seen++;
      if (hopper_pulse) pulses_seen++;
    end
    checkOutput("midrst_no_resume_busy", 32'(busy_seen), 32'd0);
    checkOutput("midrst_no_resume_pulse", 32'(pulses_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
